// File: rtl/pmux_pkg.sv
// Shared definitions for the pipelined N-to-1 select stage: FSM state encoding
// and the select-width helper used to size the index field.
package pmux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Bits needed to index n words; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_select_nto1.sv
// Combinational N-to-1 word selector; out-of-range indices yield a zero word
// and raise err.
module mux_select_nto1
  import pmux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);

  // With NUM_IN a power of two this compare folds to constant 0.
  assign err = ({1'b0, in_sel} >= (SEL_W + 1)'(NUM_IN));

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) word = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipelined_mux_nto1.sv
// Registered N-to-1 word select with valid/ready handshake and a two-entry
// skid buffer so in_ready can be registered without losing throughput.
module pipelined_mux_nto1
  import pmux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;

  mux_select_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_select (
    .in_data (in_data),
    .in_sel  (in_sel),
    .word    (sel_word),
    .err     (sel_err)
  );

  state_t           state, next_state;
  logic             ready_q;
  logic [WIDTH-1:0] main_data, skid_data;
  logic [SEL_W-1:0] main_sel, skid_sel;
  logic             main_err, skid_err;
  logic             in_xfer, out_xfer;
  logic             load_main, main_from_skid, load_skid;

  // Ready is held low for the whole reset window, then driven by the register.
  assign in_ready  = ready_q & Rst_n;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  assign out_sel   = main_sel;
  assign out_err   = main_err;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          next_state = ST_ONE;
          load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          next_state = ST_FULL;
          load_skid  = 1'b1;
        end else if (!in_xfer && out_xfer) begin
          next_state = ST_EMPTY;
        end else if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          next_state     = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != ST_FULL);
    end
  end

  // Selection is captured at the input transfer; the skid keeps the same format.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_data <= '0;
      main_sel  <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_skid) begin
        skid_data <= sel_word;
        skid_sel  <= in_sel;
        skid_err  <= sel_err;
      end
      if (load_main) begin
        main_data <= main_from_skid ? skid_data : sel_word;
        main_sel  <= main_from_skid ? skid_sel  : in_sel;
        main_err  <= main_from_skid ? skid_err  : sel_err;
      end
    end
  end

endmodule

// File: doc/pipelined_mux_nto1.md
Name: pipelined_mux_nto1

Overview:
- Parametrised, registered N-to-1 word multiplexer with a valid/ready handshake and a 2-entry skid buffer.
- Next-generation datapath select element for the pipelined SAD datapath. Selects one of NUM_IN words of WIDTH bits and registers the result together with the select index.
- Sustains full throughput under downstream back-pressure, with a registered in_ready.
- Flags out-of-range selects.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of input words (2..16).
- SEL_W, $clog2(NUM_IN), select field width (derived; minimum 1).

Ports:
- Clk  input  1  single system clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to Clk.
- in_data  input  NUM_IN*WIDTH  packed inputs; word k = in_data[k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the word to forward.
- in_valid  input  1  upstream offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts this cycle; registered.
- out_data  output  WIDTH  selected word; registered.
- out_sel  output  SEL_W  select index that produced out_data.
- out_err  output  1  in_sel was >= NUM_IN for this beat.
- out_valid  output  1  out_data/out_sel/out_err are valid.
- out_ready  input  1  downstream consumes when high with out_valid.

Behaviour:
- Transfers:
  - Input transfer: in_valid & in_ready at the rising edge.
  - Output transfer: out_valid & out_ready at the rising edge.
- Select:
  - Word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN.
  - Otherwise word = 0 and err = 1; the beat is still accepted and forwarded.
  - Selection is sampled at input transfer only. Later changes to in_data or in_sel do not affect stored beats.
- Storage: main register (drives outputs) plus one skid register, each holding {data, sel, err}.
- State machine (2-bit):
  - EMPTY: out_valid=0, in_ready=1.
    - Input transfer -> ONE, main loaded.
  - ONE: out_valid=1, in_ready=1.
    - Input only -> FULL, skid loaded.
    - Output only -> EMPTY.
    - Input and output together -> stay ONE, main loaded with the new beat.
    - Neither -> hold.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer -> ONE, main <= skid.
    - Otherwise hold. No input can be accepted because in_ready=0.
- in_ready is a register equal to (next state != FULL). It is never combinationally dependent on out_ready.
- Latency: input transfer at edge n gives out_valid=1 after edge n; data is visible in cycle n+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO. Beats are never dropped or duplicated.
- out_data, out_sel and out_err are stable while out_valid=1 and out_ready=0.
- Reset (including mid-operation):
  - State=EMPTY; main and skid cleared to 0.
  - out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=1 after deassertion.
  - Any held beats are discarded.
- While Rst_n=0, in_ready=0 and out_valid=0.
- NUM_IN a power of 2: out_err is constant 0.

Decomposition:
- Shared package (pmux_pkg):
  - State encoding constants: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Function computing SEL_W from NUM_IN.
- Sub-module mux_select_nto1 (combinational): in_data, in_sel -> word, err. Parametrised on WIDTH and NUM_IN. Reused by other datapath stages.
- Top module holds the FSM, main/skid registers and handshake.

Test Plan:
- Basic select: WIDTH=32, NUM_IN=4; words 0x11111111/0x22222222/0x33333333/0x44444444; send in_sel=2 with out_ready=1 -> next cycle out_valid=1, out_data=0x33333333, out_sel=2, out_err=0.
- Streaming: 8 back-to-back beats, sel=0..3,0..3, out_ready=1 -> 8 consecutive out_valid cycles, data order matches, in_ready stays 1.
- Back-pressure: out_ready=0 while sending beats A,B,C -> A on outputs, B in skid, in_ready=0 after B, C held upstream. Raise out_ready -> A, B, C in order, no loss.
- Out-of-range: NUM_IN=3, in_sel=3 -> out_data=0, out_err=1, out_sel=3; next beat sel=1 -> out_err=0.
- Reset mid-operation: state FULL, assert Rst_n=0 asynchronously between edges -> out_valid=0 and out_data=0 immediately. After release: in_ready=1, EMPTY, prior beats never appear.
- Stability: hold out_ready=0 and randomise in_data each cycle -> out_data, out_sel and out_err unchanged until the output transfer.
